// File: rtl/fifo_rx_pkg.sv
// Shared constants and types for the receive-side byte FIFO.
// Bus widths, default sizing and the level-width helper live here.
package fifo_rx_pkg;

  localparam int APB_DW         = 8;
  localparam int BYTE_W         = 8;
  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_THRESH = 32;
  localparam int BIT_CNT_W      = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    APB_IDLE  = 2'd0,
    APB_READ  = 2'd1,
    APB_WRITE = 2'd2
  } apb_op_e;

  // The level counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rx_deserializer.sv
// Serial-to-byte converter, MSB first, qualified by a per-bit strobe.
// A frame-start sync discards any partial byte.
module rx_deserializer
  import fifo_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bitstream,
  input  logic              bitstream_en,
  input  logic              sync,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid
);

  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-2:0]    shift_q, shift_d;

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first so no latch is inferred; clocked blocks use non-blocking '<='.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (sync) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (bitstream_en) begin
      cnt_d   = cnt_q + BIT_CNT_W'(1);
      shift_d = {shift_q[BYTE_W-3:0], bitstream};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // The completed byte is presented in the same cycle as its last bit.
  assign byte_valid = bitstream_en && !sync && (cnt_q == '1);
  assign byte_data  = {shift_q, bitstream};

endmodule

// File: rtl/fifo_rx.sv
// Receive byte FIFO: deserialized bytes are buffered in a circular memory
// and drained by the CPU through a zero-wait-state, read-only APB slave.
module fifo_rx
  import fifo_rx_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int THRESH = DEFAULT_THRESH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bitstream,
  input  logic                          bitstream_en,
  input  logic                          sync,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  output logic [APB_DW-1:0]             prdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [level_width(DEPTH)-1:0] fifo_level,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_IRQ  = LW'(THRESH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              is_empty, is_full;
  logic              push_ok, pop_ok;
  apb_op_e           apb_op;

  rx_deserializer u_deser (
    .clk          (clk),
    .reset        (reset),
    .bitstream    (bitstream),
    .bitstream_en (bitstream_en),
    .sync         (sync),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid)
  );

  always_comb begin
    apb_op = APB_IDLE;
    if (psel && penable) apb_op = pwrite ? APB_WRITE : APB_READ;
  end

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LEVEL_FULL);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop_ok     = (apb_op == APB_READ) && !is_empty;
  assign push_ok    = byte_valid && (!is_full || pop_ok);
  assign overflow_d = overflow_q || (byte_valid && is_full && !pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only
  // observable after it has been written, and a reset would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= byte_data;
  end

  assign prdata     = is_empty ? '0 : mem[rd_ptr_q];
  assign pready     = 1'b1;
  assign pslverr    = (apb_op == APB_WRITE) || ((apb_op == APB_READ) && is_empty);
  assign fifo_level = level_q;
  assign fifo_empty = is_empty;
  assign fifo_full  = is_full;
  assign overflow   = overflow_q;
  assign irq        = (level_q >= LEVEL_IRQ);

endmodule

// File: tb/tb_fifo_rx.sv
// Directed bench for fifo_rx: the stimulus pushes expected APB responses into a
// queue and a negedge monitor pops and compares them on every access phase.
module tb_fifo_rx;
  import fifo_rx_pkg::*;

  localparam int DEPTH  = 64;
  localparam int THRESH = 32;
  localparam int LW     = 7;

  logic          clk = 1'b0;
  logic          reset, bitstream, bitstream_en, sync, psel, penable, pwrite;
  logic [7:0]    prdata;
  logic          pready, pslverr;
  logic [LW-1:0] fifo_level;
  logic          fifo_empty, fifo_full, overflow, irq;

  typedef struct {
    logic       err;
    logic       chk_data;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  fifo_rx #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bitstream    (bitstream),
    .bitstream_en (bitstream_en),
    .sync         (sync),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .fifo_level   (fifo_level),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .irq          (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every access phase consumes one expected response.
  always @(negedge clk) begin
    if (!reset && psel && penable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_access: got access with prdata=0x%0h expected none", prdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("apb_pslverr", pslverr, e.err);
        if (e.chk_data) check("apb_prdata", prdata, e.data);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  task automatic check_state(input string tag, input int lvl, input logic ovf);
    check({tag, "_level"},    fifo_level, lvl);
    check({tag, "_empty"},    fifo_empty, (lvl == 0));
    check({tag, "_full"},     fifo_full,  (lvl == DEPTH));
    check({tag, "_overflow"}, overflow,   ovf);
    check({tag, "_irq"},      irq,        (lvl >= THRESH));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_prdata"},  prdata,  0);
    check({tag, "_pready"},  pready,  1);
    check({tag, "_pslverr"}, pslverr, 0);
    check_state(tag, 0, 1'b0);
  endtask

  task automatic strobe(input logic b, input int gap);
    @(posedge clk); #1;
    bitstream    = b;
    bitstream_en = 1'b1;
    @(posedge clk); #1;
    bitstream_en = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) strobe(b[i], gap);
    if (model_q.size() < DEPTH) model_q.push_back(b);
  endtask

  task automatic apb_access(input logic wr);
    exp_t e;
    @(posedge clk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    if (wr) begin
      e.err = 1'b1; e.chk_data = 1'b0; e.data = 8'h00;
    end else if (model_q.size() == 0) begin
      e.err = 1'b1; e.chk_data = 1'b1; e.data = 8'h00;
    end else begin
      e.err = 1'b0; e.chk_data = 1'b1; e.data = model_q.pop_front();
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    model_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] nb;
    logic [4:0] partial;
    exp_t       e;

    reset = 1'b1; bitstream = 1'b0; bitstream_en = 1'b0; sync = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Two bytes with a strobe every 4 cycles, then read them back.
    send_byte(8'hA5, 2);
    send_byte(8'h3C, 2);
    check_state("two_bytes", 2, 1'b0);
    apb_access(1'b0);
    apb_access(1'b0);
    check_state("two_drained", 0, 1'b0);

    // Error accesses: read while empty, and any write.
    apb_access(1'b0);
    check_state("empty_read", 0, 1'b0);
    apb_access(1'b1);
    check_state("write_err", 0, 1'b0);

    // Sync after 5 bits, coinciding with a strobe whose bit must be dropped.
    partial = 5'b10110;
    for (int i = 4; i >= 0; i--) strobe(partial[i], 0);
    @(posedge clk); #1;
    sync = 1'b1; bitstream_en = 1'b1; bitstream = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0; bitstream_en = 1'b0;
    check_state("after_sync", 0, 1'b0);
    send_byte(8'h81, 0);
    check_state("sync_byte", 1, 1'b0);
    apb_access(1'b0);

    // irq threshold.
    for (int i = 0; i < 31; i++) send_byte(8'(8'h40 + i), 0);
    check_state("irq_31", 31, 1'b0);
    send_byte(8'h5F, 0);
    check_state("irq_32", 32, 1'b0);
    apb_access(1'b0);
    check_state("irq_read", 31, 1'b0);
    repeat (31) apb_access(1'b0);
    check_state("irq_drained", 0, 1'b0);

    // Fill to DEPTH, overflow with 0xFF, drain, then wrap the pointers.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0);
    check_state("full", 64, 1'b0);
    send_byte(8'hFF, 0);
    check_state("overflow", 64, 1'b1);
    repeat (DEPTH) apb_access(1'b0);
    check_state("full_drained", 0, 1'b1);
    for (int i = 0; i < 50; i++) send_byte(8'(8'h80 + i), 0);
    check_state("wrap_50", 50, 1'b1);
    repeat (50) apb_access(1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i), 0);
    repeat (20) apb_access(1'b0);
    check_state("wrap_done", 0, 1'b1);

    // Full FIFO: last bit of a byte lands in the same cycle as a read pop.
    pulse_reset();
    check_state("rst2", 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), 0);
    check_state("full2", 64, 1'b0);
    nb = 8'h5A;
    for (int i = 7; i >= 1; i--) strobe(nb[i], 0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    e.err = 1'b0; e.chk_data = 1'b1; e.data = model_q.pop_front();
    exp_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1; bitstream = nb[0]; bitstream_en = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; bitstream_en = 1'b0;
    model_q.push_back(nb);
    check_state("coincide", 64, 1'b0);
    repeat (DEPTH) apb_access(1'b0);
    check_state("coincide_drained", 0, 1'b0);

    // Reset in the middle of a byte with data buffered.
    for (int i = 0; i < 40; i++) send_byte(8'(8'h20 + i), 0);
    check_state("pre_reset", 40, 1'b0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    model_q.delete();
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(8'h77, 0);
    check_state("post_reset_byte", 1, 1'b0);
    apb_access(1'b0);
    check_state("post_reset_drained", 0, 1'b0);

    check("scoreboard_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
